ysyx_22041211_pc_fetch_ctrl: RTL

//  Program-counter register and fetch-request sequencer; consumes the 2-bit PC-select code from the branch/jump decision stage.

---
 rtl/ysyx_22041211_pkg.sv | 23 ++
 rtl/ysyx_22041211_npc_mux.sv | 44 ++++
 rtl/ysyx_22041211_pc_fetch_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22041211_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041211_pkg
// Shared definitions for the PC / fetch-control slice:
//   - PC_SRC_* : next-PC select codes produced by the branch/jump decision
//   - fetch_state_e : fetch sequencer state encoding
//   - RESET_PC_DEFAULT : architectural PC after reset
// ---------------------------------------------------------------------------
package ysyx_22041211_pkg;

    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_BR   = 2'b01;
    localparam logic [1:0] PC_SRC_JALR = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_EXEC = 2'b10,
        ST_TRAP = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/ysyx_22041211_npc_mux.sv
// ---------------------------------------------------------------------------
// ysyx_22041211_npc_mux
// Combinational next-PC selection.
// Ports:
//   pc_i        in  ADDR_W  current PC
//   imm_i       in  ADDR_W  sign-extended immediate
//   rs1_data_i  in  ADDR_W  rs1 operand (jalr base)
//   pc_src_i    in  2       select: 00 seq, 01 pc+imm, 10 jalr, 11 as seq
//   npc_o       out ADDR_W  selected next PC (wraps silently)
//   pc_plus4_o  out ADDR_W  pc + 4
// ---------------------------------------------------------------------------
module ysyx_22041211_npc_mux
    import ysyx_22041211_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] imm_i,
    input  logic [ADDR_W-1:0] rs1_data_i,
    input  logic [1:0]        pc_src_i,
    output logic [ADDR_W-1:0] npc_o,
    output logic [ADDR_W-1:0] pc_plus4_o
);

    // jalr targets always have bit 0 cleared
    localparam logic [ADDR_W-1:0] JALR_MASK = ~{{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] jalr_sum_s;

    assign pc_plus4_o = pc_i + ADDR_W'(32'd4);
    assign jalr_sum_s = rs1_data_i + imm_i;

    // Next-PC select; the unused code 11 falls back to sequential
    always_comb begin
        npc_o = pc_plus4_o;
        case (pc_src_i)
            PC_SRC_SEQ:  npc_o = pc_plus4_o;
            PC_SRC_BR:   npc_o = pc_i + imm_i;
            PC_SRC_JALR: npc_o = jalr_sum_s & JALR_MASK;
            default:     npc_o = pc_plus4_o;
        endcase
    end

endmodule

// File: rtl/ysyx_22041211_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22041211_pc_fetch_ctrl
// Architectural PC register plus a fetch sequencer: IDLE (one bubble after
// reset) -> REQ (fetch handshake) -> EXEC (wait for commit) -> REQ ...
// Optional feature macro: YSYX_22041211_MISALIGN_CHK_EN
//   defined   : a committed target with npc[1:0]!=0 is not loaded; the
//               sticky misalign flag is set and the FSM parks in TRAP until
//               reset.
//   undefined : targets are loaded unchecked, misalign is tied 0.
// Ports:
//   clk           in  1       rising-edge clock
//   rst           in  1       synchronous active-low reset
//   pc_src        in  2       next-PC select from the branch stage
//   imm           in  ADDR_W  immediate of the committing instruction
//   rs1_data      in  ADDR_W  jalr base
//   commit_valid  in  1       execute finished instruction at pc
//   fetch_valid   out 1       fetch request valid (registered)
//   fetch_ready   in  1       instruction memory accepts request
//   fetch_addr    out ADDR_W  fetch address (== pc)
//   pc            out ADDR_W  architectural PC
//   pc_plus4      out ADDR_W  pc + 4 (combinational)
//   redirect      out 1       one-cycle pulse after a non-sequential commit
//   misalign      out 1       sticky misaligned-target flag
// ---------------------------------------------------------------------------
module ysyx_22041211_pc_fetch_ctrl
    import ysyx_22041211_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] rs1_data,
    input  logic              commit_valid,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              redirect,
    output logic              misalign
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              fetch_valid_q;
    logic              redirect_q;
    logic [ADDR_W-1:0] npc_d;
    logic [ADDR_W-1:0] pc_plus4_s;
`ifdef YSYX_22041211_MISALIGN_CHK_EN
    logic              misalign_q;
`endif

    ysyx_22041211_npc_mux #(
        .ADDR_W (ADDR_W)
    ) u_npc_mux (
        .pc_i       (pc_q),
        .imm_i      (imm),
        .rs1_data_i (rs1_data),
        .pc_src_i   (pc_src),
        .npc_o      (npc_d),
        .pc_plus4_o (pc_plus4_s)
    );

    // Fetch FSM with PC, fetch_valid, redirect and misalign held in flops
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            redirect_q    <= 1'b0;
`ifdef YSYX_22041211_MISALIGN_CHK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            // redirect is a pulse: cleared unless the commit below raises it
            redirect_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q       <= ST_REQ;
                    fetch_valid_q <= 1'b1;
                end
                ST_REQ: begin
                    // commit_valid is deliberately not looked at here
                    if (fetch_ready) begin
                        state_q       <= ST_EXEC;
                        fetch_valid_q <= 1'b0;
                    end else begin
                        state_q       <= ST_REQ;
                        fetch_valid_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (commit_valid) begin
`ifdef YSYX_22041211_MISALIGN_CHK_EN
                        if (npc_d[1:0] != 2'b00) begin
                            state_q       <= ST_TRAP;
                            fetch_valid_q <= 1'b0;
                            misalign_q    <= 1'b1;
                        end else begin
                            pc_q          <= npc_d;
                            redirect_q    <= (npc_d != pc_plus4_s);
                            state_q       <= ST_REQ;
                            fetch_valid_q <= 1'b1;
                        end
`else
                        pc_q          <= npc_d;
                        redirect_q    <= (npc_d != pc_plus4_s);
                        state_q       <= ST_REQ;
                        fetch_valid_q <= 1'b1;
`endif
                    end else begin
                        state_q       <= ST_EXEC;
                        fetch_valid_q <= 1'b0;
                    end
                end
`ifdef YSYX_22041211_MISALIGN_CHK_EN
                ST_TRAP: begin
                    // parked until reset; pc frozen
                    state_q       <= ST_TRAP;
                    fetch_valid_q <= 1'b0;
                end
`endif
                default: begin
                    state_q       <= ST_IDLE;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_addr  = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_s;
    assign redirect    = redirect_q;
`ifdef YSYX_22041211_MISALIGN_CHK_EN
    assign misalign    = misalign_q;
`else
    assign misalign    = 1'b0;
`endif

endmodule
